key_debounce_multi: RTL

Parametrised multi-channel key conditioner for the board's push-buttons. It takes up to `NUM_KEYS` raw, bouncing, asynchronous key inputs and synchronises and debounces each one independently. For each key it produces a stable level plus one-cycle event pulses: press, release, short click, long-press and auto-repeat. It sits between the board pins and the game/control FSMs. It supersedes single-key, press-only debouncing with configurable polarity, timing and hold-behaviour events.

---
 rtl/key_debounce_multi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per-key 2-flop sync, debounce, and
// press/release/click/long/repeat event pulses. One key_debounce_chan per key.

module key_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 24900,
    parameter int LONG_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam int REP_LAST_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_LAST_I);
    localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {RELEASED, HELD_SHORT, HELD_LONG} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            click_q, click_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;

    logic differ, accept, press_ev, release_ev;

    // Debounce datapath: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_comb begin
        sync_d     = {sync_q[0], key_in};
        differ     = (sync_q[1] != level_q);
        accept     = differ && (db_cnt_q == DB_LAST);
        db_cnt_d   = '0;
        if (differ && !accept)
            db_cnt_d = db_cnt_q + DW'(1);
        level_d    = accept ? ~level_q : level_q;
        press_ev   = accept && !level_q;
        release_ev = accept && level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RELEASED:   if (press_ev) state_d = HELD_SHORT;
            HELD_SHORT: begin
                if (release_ev)                   state_d = RELEASED;
                else if (hold_cnt_q == HOLD_LAST) state_d = HELD_LONG;
            end
            HELD_LONG:  if (release_ev) state_d = RELEASED;
            default:    state_d = RELEASED;
        endcase
    end

    // Release wins over a coincident long or repeat edge.
    always_comb begin
        press_d    = press_ev;
        release_d  = release_ev;
        click_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        case (state_q)
            HELD_SHORT: begin
                click_d    = release_ev;
                long_d     = !release_ev && (hold_cnt_q == HOLD_LAST);
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HW'(1);
            end
            HELD_LONG: begin
                hold_cnt_d = hold_cnt_q;
                if (REPEAT_EN) begin
                    repeat_d  = !release_ev && (rep_cnt_q == REP_LAST);
                    rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + RW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

module key_debounce_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 24900,
    parameter int LONG_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] click_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    logic [NUM_KEYS-1:0] key_norm;

    assign key_norm = (ACTIVE_HIGH != 0) ? key : ~key;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .key_in       (key_norm[i]),
            .key_level    (key_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .click_pulse  (click_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule
